// File: rtl/mul_u48_u24_add_8.sv
// Pipelined unsigned multiply-add out = src0*src1 + src2 (48 x 24 + 23), 8-cycle latency, global en stall.
// Optional remainder sanity flag (src2 >= src1) enabled by defining MULADD_REMCHK_EN.
module mul_u48_u24_add_8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        vldin,
    input  logic [47:0] src0,
    input  logic [23:0] src1,
    input  logic [22:0] src2,
    output logic        vldout,
    output logic [47:0] out,
    output logic        ovf
`ifdef MULADD_REMCHK_EN
    ,
    output logic        remerr
`endif
);

    localparam int unsigned AW = 72;
    localparam int unsigned MW = 48;
    localparam int unsigned BW = 24;
    localparam int unsigned RW = 23;
    localparam int unsigned NS = 6;

    logic [AW-1:0] mcand_q  [0:NS-1];
    logic [AW-1:0] mcand_d  [0:NS-1];
    logic [BW-1:0] mplier_q [0:NS-1];
    logic [BW-1:0] mplier_d [0:NS-1];
    logic [RW-1:0] addend_q [0:NS];
    logic [RW-1:0] addend_d [0:NS];
    logic [AW-1:0] acc_q    [1:NS];
    logic [AW-1:0] acc_d    [1:NS];
    logic [NS:0]   vld_q, vld_d;
    logic [MW-1:0] out_q, out_d;
    logic          ovf_q, ovf_d;
    logic          vldout_q, vldout_d;
    logic [AW-1:0] sum_c;
`ifdef MULADD_REMCHK_EN
    logic [NS:0]   rem_q, rem_d;
    logic          remerr_q, remerr_d;
`endif

    // Four shift-add steps over multiplier bits [base+3:base], LSB first.
    function automatic logic [AW-1:0] stage_add(input logic [AW-1:0] acc_in,
                                                input logic [AW-1:0] mc,
                                                input logic [BW-1:0] mp,
                                                input int unsigned   base);
        logic [AW-1:0] acc;
        logic [4:0]    idx;
        acc = acc_in;
        for (int unsigned b = 0; b < 4; b++) begin
            idx = 5'(base + b);
            if (mp[idx]) acc = acc + (mc << idx);
        end
        return acc;
    endfunction

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        addend_d = addend_q;
        acc_d    = acc_q;
        vld_d    = vld_q;
        out_d    = out_q;
        ovf_d    = ovf_q;
        vldout_d = vldout_q;
        sum_c    = acc_q[NS] + AW'(addend_q[NS]);
`ifdef MULADD_REMCHK_EN
        rem_d    = rem_q;
        remerr_d = remerr_q;
`endif
        if (en) begin
            vld_d[0]    = vldin;
            mcand_d[0]  = AW'(src0);
            mplier_d[0] = src1;
            addend_d[0] = src2;
`ifdef MULADD_REMCHK_EN
            rem_d[0]    = ({1'b0, src2} >= src1);
`endif
            for (int unsigned k = 1; k < NS; k++) begin
                mcand_d[k]  = mcand_q[k-1];
                mplier_d[k] = mplier_q[k-1];
            end
            for (int unsigned k = 1; k <= NS; k++) begin
                vld_d[k]    = vld_q[k-1];
                addend_d[k] = addend_q[k-1];
`ifdef MULADD_REMCHK_EN
                rem_d[k]    = rem_q[k-1];
`endif
            end
            acc_d[1] = stage_add(AW'(0), mcand_q[0], mplier_q[0], 0);
            for (int unsigned k = 2; k <= NS; k++) begin
                acc_d[k] = stage_add(acc_q[k-1], mcand_q[k-1], mplier_q[k-1], 4 * (k - 1));
            end
            // Worst case product plus addend stays below 2^72, so sum_c never wraps.
            out_d    = sum_c[MW-1:0];
            ovf_d    = |sum_c[AW-1:MW];
            vldout_d = vld_q[NS];
`ifdef MULADD_REMCHK_EN
            remerr_d = rem_q[NS];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NS; k++) begin
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
            end
            for (int unsigned k = 0; k <= NS; k++) addend_q[k] <= '0;
            for (int unsigned k = 1; k <= NS; k++) acc_q[k] <= '0;
            vld_q    <= '0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
            vldout_q <= 1'b0;
`ifdef MULADD_REMCHK_EN
            rem_q    <= '0;
            remerr_q <= 1'b0;
`endif
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            addend_q <= addend_d;
            acc_q    <= acc_d;
            vld_q    <= vld_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
            vldout_q <= vldout_d;
`ifdef MULADD_REMCHK_EN
            rem_q    <= rem_d;
            remerr_q <= remerr_d;
`endif
        end
    end

    assign out    = out_q;
    assign ovf    = ovf_q;
    assign vldout = vldout_q;
`ifdef MULADD_REMCHK_EN
    assign remerr = remerr_q;
`endif

endmodule
